// File: rtl/regfile_pkg.sv
// Shared constants and types for the 0dMIPS register file.
package regfile_pkg;

    localparam int unsigned REG_COUNT  = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array select, R0 forced to zero, optional
// same-cycle write forwarding (enabled by defining REGFILE_BYPASS_EN).
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned width = 64
) (
    input  logic [REG_COUNT-1:0][width-1:0] regs,
    input  reg_addr_t                       addr,
`ifdef REGFILE_BYPASS_EN
    input  logic                            fwd_en,
    input  reg_addr_t                       w_addr,
    input  logic [width-1:0]                w_data,
`endif
    output logic [width-1:0]                data
);

    // Select the addressed register; forwarding takes priority when active.
    always_comb begin
        data = regs[addr];
        if (addr == REG_ZERO) begin
            data = '0;
        end
`ifdef REGFILE_BYPASS_EN
        if (fwd_en && (addr == w_addr)) begin
            data = w_data;
        end
`endif
    end

endmodule

// File: rtl/regfile.sv
// 32 x width register file, R0 hard-wired to zero, two combinational read
// ports and one synchronous write port. Defining REGFILE_BYPASS_EN forwards
// the write data to a read port addressing the register being written.
module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned       width       = 64,
    parameter logic [width-1:0]  reset_value = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  reg_addr_t                       A_addr,
    output logic [width-1:0]                A_data,
    input  reg_addr_t                       B_addr,
    output logic [width-1:0]                B_data,
    input  reg_addr_t                       W_addr,
    input  logic [width-1:0]                W_data,
    input  logic                            wr_enable,
    output logic [REG_COUNT-1:0][width-1:0] debug_reg_out
);

    // R0 has no storage; only R1..R31 are flops.
    logic [REG_COUNT-1:1][width-1:0] regs_q;
    logic [REG_COUNT-1:0][width-1:0] regs_view;

    // Write decode with asynchronous reset of R1..R31.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= {(REG_COUNT-1){reset_value}};
        end else if (wr_enable && (W_addr != REG_ZERO)) begin
            regs_q[W_addr] <= W_data;
        end
    end

    // Full array view with R0 tied to zero, also exported for debug.
    assign regs_view     = {regs_q, width'(0)};
    assign debug_reg_out = regs_view;

`ifdef REGFILE_BYPASS_EN
    logic fwd_en;

    // Forward only writes that will actually land at the next edge.
    assign fwd_en = reset && wr_enable && (W_addr != REG_ZERO);
`endif

    regfile_read_port #(.width(width)) u_port_a (
        .regs   (regs_view),
        .addr   (A_addr),
`ifdef REGFILE_BYPASS_EN
        .fwd_en (fwd_en),
        .w_addr (W_addr),
        .w_data (W_data),
`endif
        .data   (A_data)
    );

    regfile_read_port #(.width(width)) u_port_b (
        .regs   (regs_view),
        .addr   (B_addr),
`ifdef REGFILE_BYPASS_EN
        .fwd_en (fwd_en),
        .w_addr (W_addr),
        .w_data (W_data),
`endif
        .data   (B_data)
    );

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: the driver pushes expected values, a monitor
// pops and compares them against the live DUT outputs.
module tb_regfile;
    import regfile_pkg::*;

    localparam int unsigned W  = 64;
    localparam logic [W-1:0] RV = 64'h5a5a_0000_1234_5678;

    logic                        clk;
    logic                        reset;
    reg_addr_t                   A_addr, B_addr, W_addr;
    logic [W-1:0]                A_data, B_data, W_data;
    logic                        wr_enable;
    logic [REG_COUNT-1:0][W-1:0] debug_reg_out;

    regfile #(.width(W), .reset_value(RV)) dut (
        .clk           (clk),
        .reset         (reset),
        .A_addr        (A_addr),
        .A_data        (A_data),
        .B_addr        (B_addr),
        .B_data        (B_data),
        .W_addr        (W_addr),
        .W_data        (W_data),
        .wr_enable     (wr_enable),
        .debug_reg_out (debug_reg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = A_data, 1 = B_data, 2 = debug_reg_out[idx]
    typedef struct {
        int           kind;
        int           idx;
        logic [W-1:0] exp;
        string        name;
    } chk_t;

    chk_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic expect_out(input int kind, input int idx, input logic [W-1:0] exp,
                              input string name);
        chk_t c;
        c.kind = kind;
        c.idx  = idx;
        c.exp  = exp;
        c.name = name;
        sb.push_back(c);
    endtask

    // Yield so the monitor samples while inputs are still stable.
    task automatic settle();
        #1;
    endtask

    // Monitor: compares each expectation against the DUT as it is presented.
    initial begin
        chk_t         c;
        logic [W-1:0] act;
        forever begin
            wait (sb.size() != 0);
            c = sb.pop_front();
            case (c.kind)
                0:       act = A_data;
                1:       act = B_data;
                default: act = debug_reg_out[c.idx];
            endcase
            checks++;
            if (act !== c.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] bypass_or_old;

        // Reset held low with a write pending: nothing may change.
        reset     = 1'b0;
        wr_enable = 1'b1;
        W_addr    = 5'd1;
        W_data    = 64'hdeadbeef;
        A_addr    = 5'd1;
        B_addr    = 5'd0;
        repeat (2) @(posedge clk);
        #2;
        expect_out(2, 1, RV, "rst_dbg1");
        expect_out(0, 0, RV, "rst_a1");
        expect_out(1, 0, '0, "rst_b0");
        expect_out(2, 0, '0, "rst_dbg0");
        expect_out(2, 31, RV, "rst_dbg31");
        settle();

        // Release between edges; first write lands on the next posedge.
        @(negedge clk);
        reset = 1'b1;
        settle();
        expect_out(2, 1, RV, "rel_pre_dbg1");
        settle();
        @(posedge clk);
        #2;
        expect_out(2, 1, 64'hdeadbeef, "rel_wr_dbg1");
        expect_out(0, 0, 64'hdeadbeef, "rel_wr_a1");
        settle();

        // Write R21, read it on A in the same cycle and after the edge.
        @(negedge clk);
        W_addr = 5'h15;
        W_data = 64'hcafebabe;
        A_addr = 5'h15;
`ifdef REGFILE_BYPASS_EN
        bypass_or_old = 64'hcafebabe;
`else
        bypass_or_old = RV;
`endif
        settle();
        expect_out(0, 0, bypass_or_old, "rdw_a21_pre");
        expect_out(2, 21, RV, "rdw_dbg21_pre");
        settle();
        @(posedge clk);
        #2;
        expect_out(0, 0, 64'hcafebabe, "wr_a21");
        settle();

        // Write disabled: R20 untouched; both ports on the same index.
        @(negedge clk);
        wr_enable = 1'b0;
        W_addr    = 5'h14;
        W_data    = 64'hffff;
        A_addr    = 5'h14;
        B_addr    = 5'h14;
        @(posedge clk);
        #2;
        expect_out(1, 0, RV, "wdis_b20");
        expect_out(0, 0, RV, "wdis_a20");
        expect_out(2, 20, RV, "wdis_dbg20");
        settle();

        // R0 writes are discarded and never forwarded.
        @(negedge clk);
        wr_enable = 1'b1;
        W_addr    = 5'd0;
        W_data    = '1;
        A_addr    = 5'd0;
        B_addr    = 5'd1;
        settle();
        expect_out(0, 0, '0, "r0_a_pre");
        settle();
        @(posedge clk);
        #2;
        expect_out(0, 0, '0, "r0_a_post");
        expect_out(2, 0, '0, "r0_dbg0");
        expect_out(1, 0, 64'hdeadbeef, "r0_b1_intact");
        settle();

        // Top index boundary, full-width data.
        @(negedge clk);
        W_addr = 5'd31;
        W_data = 64'h8000_0000_0000_0001;
        B_addr = 5'd31;
        @(posedge clk);
        #2;
        expect_out(1, 0, 64'h8000_0000_0000_0001, "wr_b31");
        expect_out(2, 30, RV, "wr_dbg30_intact");
        settle();

        // Async reset between edges with a write pending.
        @(negedge clk);
        W_addr = 5'h15;
        W_data = 64'h1111;
        A_addr = 5'h15;
        B_addr = 5'd1;
        #2;
        reset = 1'b0;
        settle();
        expect_out(2, 1, RV, "arst_dbg1");
        expect_out(2, 21, RV, "arst_dbg21");
        expect_out(0, 0, RV, "arst_a21");
        expect_out(1, 0, RV, "arst_b1");
        expect_out(2, 31, RV, "arst_dbg31");
        settle();
        @(posedge clk);
        #2;
        expect_out(2, 21, RV, "arst_edge_dbg21");
        settle();

        // Recovery: write works again after release.
        @(negedge clk);
        reset  = 1'b1;
        W_addr = 5'd2;
        W_data = 64'h0123_4567_89ab_cdef;
        A_addr = 5'd2;
        @(posedge clk);
        #2;
        expect_out(0, 0, 64'h0123_4567_89ab_cdef, "rec_a2");
        expect_out(2, 21, RV, "rec_dbg21");
        settle();

        for (int i = 0; i < 100 && sb.size() != 0; i++) #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
